// File: rtl/multicycle_control.sv
// multicycle_control: sequential instruction controller.
// Accepts one instruction over a valid/ready handshake. It steps the instruction
// through DECODE/EXEC/MEM/WB and drives stage-qualified strobes to the ALU,
// the data memory and the register file.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   instr_valid/ready     instruction handshake (ready only in IDLE)
//   instruction           instruction word
//   mem_ready             data memory finished the access (used only in MEM)
//   ctrl_word             latched decode {zeros, erf, rs, rt, rd, ctl_mux_alu,
//                         alu_control[2:0], cs, wr, ctl_mux_reg}
//   alu_en/mem_cs/mem_wr/rf_we  stage strobes
//   done, illegal, mem_err      one-cycle status pulses
//
// Optional feature: define MULTICYCLE_CONTROL_MUL_EN to decode funct 50 as MUL.
// When it is not defined, funct 50 is illegal.
module multicycle_control #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter logic [5:0]  OP_RTYPE    = 6'b000010,
    parameter logic [5:0]  OP_LW       = 6'b000011,
    parameter logic [5:0]  OP_SW       = 6'b000100,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [DATA_WIDTH-1:0] instruction,
    input  logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] ctrl_word,
    output logic                  alu_en,
    output logic                  mem_cs,
    output logic                  mem_wr,
    output logic                  rf_we,
    output logic                  done,
    output logic                  illegal,
    output logic                  mem_err
);

    localparam int unsigned CNT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned WORD_W = 23;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  done_q;

    logic [5:0]        dec_op;
    logic [5:0]        dec_funct;
    logic [2:0]        dec_alu;
    logic [4:0]        dec_rd;
    logic              dec_mem;
    logic              dec_wr;
    logic              dec_legal;
    logic              dec_erf;
    logic [WORD_W-1:0] dec_word;

    // Only some instruction bits feed the decode. This marks the rest as intentionally unused.
    logic unused_instr;
    assign unused_instr = &{1'b0, instr_q};

    // Decode the captured instruction into a control word.
    always_comb begin
        dec_op    = instr_q[31:26];
        dec_funct = instr_q[5:0];
        dec_alu   = 3'b000;
        dec_rd    = instr_q[15:11];
        dec_mem   = 1'b0;
        dec_wr    = 1'b0;
        dec_legal = 1'b0;
        if (dec_op == OP_RTYPE) begin
            case (dec_funct)
                6'd32:   dec_alu = 3'b001;
                6'd34:   dec_alu = 3'b010;
                6'd36:   dec_alu = 3'b011;
                6'd37:   dec_alu = 3'b100;
`ifdef MULTICYCLE_CONTROL_MUL_EN
                6'd50:   dec_alu = 3'b101;
`endif
                default: dec_alu = 3'b000;
            endcase
            dec_legal = (dec_alu != 3'b000);
        end else if (dec_op == OP_LW || dec_op == OP_SW) begin
            dec_alu   = 3'b001;
            dec_rd    = instr_q[20:16];
            dec_mem   = 1'b1;
            dec_wr    = (dec_op == OP_SW);
            dec_legal = 1'b1;
        end
        dec_erf  = dec_legal && !dec_wr;
        dec_word = {dec_erf, instr_q[25:21], instr_q[20:16], dec_rd,
                    dec_mem, dec_alu, dec_mem, dec_wr, dec_mem};
    end

    // The SW completion is signalled in the same cycle that mem_ready arrives.
    assign done = done_q | (mem_wr & mem_ready);

    // Sequencer and registered strobes. Each strobe is set on the edge that enters its stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            instr_q     <= '0;
            ctrl_word   <= '0;
            wait_cnt    <= '0;
            instr_ready <= 1'b1;
            alu_en      <= 1'b0;
            mem_cs      <= 1'b0;
            mem_wr      <= 1'b0;
            rf_we       <= 1'b0;
            done_q      <= 1'b0;
            illegal     <= 1'b0;
            mem_err     <= 1'b0;
        end else begin
            alu_en  <= 1'b0;
            mem_cs  <= 1'b0;
            mem_wr  <= 1'b0;
            rf_we   <= 1'b0;
            done_q  <= 1'b0;
            illegal <= 1'b0;
            mem_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q     <= instruction;
                        instr_ready <= 1'b0;
                        state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    ctrl_word <= DATA_WIDTH'(dec_word);
                    if (dec_legal) begin
                        alu_en <= 1'b1;
                        state  <= S_EXEC;
                    end else begin
                        illegal     <= 1'b1;
                        instr_ready <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    // The cs bit of the latched word separates memory ops from R-type.
                    if (ctrl_word[2]) begin
                        mem_cs   <= 1'b1;
                        mem_wr   <= ctrl_word[1];
                        wait_cnt <= '0;
                        state    <= S_MEM;
                    end else begin
                        rf_we  <= 1'b1;
                        done_q <= 1'b1;
                        state  <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (ctrl_word[1]) begin
                            instr_ready <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            rf_we  <= 1'b1;
                            done_q <= 1'b1;
                            state  <= S_WB;
                        end
                    end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                        mem_err     <= 1'b1;
                        instr_ready <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        mem_cs   <= 1'b1;
                        mem_wr   <= ctrl_word[1];
                    end
                end
                S_WB: begin
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instruction = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] ctrl_word;
    logic        alu_en, mem_cs, mem_wr, rf_we, done, illegal, mem_err;

    int vectors = 0;
    int miscompares = 0;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .mem_ready(mem_ready),
        .ctrl_word(ctrl_word), .alu_en(alu_en), .mem_cs(mem_cs),
        .mem_wr(mem_wr), .rf_we(rf_we), .done(done),
        .illegal(illegal), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // {instr_ready, alu_en, mem_cs, mem_wr, rf_we, done, illegal, mem_err}
    function automatic logic [7:0] obs();
        return {instr_ready, alu_en, mem_cs, mem_wr, rf_we, done, illegal, mem_err};
    endfunction

    // Reference decode: kind 0 illegal, 1 R-type, 2 LW, 3 SW; expected control word.
    function automatic void model(input logic [31:0] ins, output int kind, output logic [31:0] word);
        int op, fn, alu, rd, rs, rt, erf, memop, wr;
        op = int'(ins[31:26]); fn = int'(ins[5:0]);
        rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
        alu = 0; kind = 0;
        if (op == 2) begin
            if (fn == 32) alu = 1;
            else if (fn == 34) alu = 2;
            else if (fn == 36) alu = 3;
            else if (fn == 37) alu = 4;
`ifdef MULTICYCLE_CONTROL_MUL_EN
            else if (fn == 50) alu = 5;
`endif
            kind = (alu != 0) ? 1 : 0;
        end else if (op == 3) kind = 2;
        else if (op == 4) kind = 3;
        memop = (kind >= 2) ? 1 : 0;
        wr    = (kind == 3) ? 1 : 0;
        erf   = (kind == 1 || kind == 2) ? 1 : 0;
        if (memop == 1) begin rd = rt; alu = 1; end
        word = 32'(erf * (1 << 22) + rs * (1 << 17) + rt * (1 << 12) + rd * (1 << 7)
                 + memop * 64 + alu * 8 + memop * 4 + wr * 2 + memop);
    endfunction

    // Runs one instruction from the cycle after acceptance; lat = MEM cycle with mem_ready (0 = never).
    task automatic follow(input logic [31:0] ins, input int lat);
        int kind, n;
        logic [31:0] w, mask;
        logic [7:0] exp_q[$];
        bit mr_q[$];
        bit hit, sw;
        model(ins, kind, w);
        mask = (kind == 0) ? 32'h007F_F000 : 32'hFFFF_FFFF;
        sw = (kind == 3);
        exp_q.push_back(8'b0000_0000); mr_q.push_back(1'($urandom));
        if (kind == 0) begin
            exp_q.push_back(8'b1000_0010); mr_q.push_back(1'($urandom));
        end else begin
            exp_q.push_back(8'b0100_0000); mr_q.push_back(1'($urandom));
            if (kind == 1) begin
                exp_q.push_back(8'b0000_1100); mr_q.push_back(1'($urandom));
                exp_q.push_back(8'b1000_0000); mr_q.push_back(1'($urandom));
            end else begin
                n = (lat >= 1 && lat <= T) ? lat : T;
                for (int m = 1; m <= n; m++) begin
                    hit = (m == lat);
                    exp_q.push_back({3'b001, sw, 1'b0, sw && hit, 2'b00});
                    mr_q.push_back(hit);
                end
                if (lat >= 1 && lat <= T) begin
                    if (!sw) begin
                        exp_q.push_back(8'b0000_1100); mr_q.push_back(1'($urandom));
                    end
                    exp_q.push_back(8'b1000_0000); mr_q.push_back(1'($urandom));
                end else begin
                    exp_q.push_back(8'b1000_0001); mr_q.push_back(1'($urandom));
                end
            end
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            instr_valid = 1'b0;
            instruction = $urandom;
            mem_ready   = mr_q[i];
            #1;
            vectors++;
            if (obs() !== exp_q[i]) begin
                miscompares++;
                $display("FAIL strobes ins=%08h cycle %0d: got %b expected %b", ins, i + 1, obs(), exp_q[i]);
            end
            if (i >= 1) begin
                vectors++;
                if ((ctrl_word & mask) !== (w & mask)) begin
                    miscompares++;
                    $display("FAIL ctrl_word ins=%08h cycle %0d: got %08h expected %08h", ins, i + 1, ctrl_word & mask, w & mask);
                end
            end
        end
    endtask

    task automatic run_instr(input logic [31:0] ins, input int lat);
        vectors++;
        if (instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_before ins=%08h: got %b expected 1", ins, instr_ready);
        end
        instr_valid = 1'b1;
        instruction = ins;
        follow(ins, lat);
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        @(posedge clk); #2;
        vectors++;
        if (obs() !== 8'b1000_0000 || ctrl_word !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: got %b/%08h expected 10000000/00000000", obs(), ctrl_word);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();      run_instr(32'h082252A0, 0); endtask
    task automatic test_lw();       run_instr(32'h0C640010, 3); endtask
    task automatic test_sw_timeout(); run_instr(32'h10650008, 0); endtask

    task automatic test_illegal();
        run_instr(32'hFC000000, 0);
        run_instr(32'h08221833, 0);
    endtask

    task automatic test_mul();      run_instr(32'h08A63032, 0); endtask

    task automatic test_reset_mid();
        vectors++;
        if (instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_ready: got %b expected 1", instr_ready);
        end
        instr_valid = 1'b1;
        instruction = 32'h082252A0;
        @(posedge clk); #2;
        vectors++;
        if (obs() !== 8'b0000_0000) begin
            miscompares++;
            $display("FAIL reset_mid_decode: got %b expected 00000000", obs());
        end
        @(posedge clk); #1 rst_n = 1'b0; #1;
        vectors++;
        if (obs() !== 8'b0100_0000) begin
            miscompares++;
            $display("FAIL reset_mid_exec: got %b expected 01000000", obs());
        end
        @(posedge clk); #1 rst_n = 1'b1; #1;
        vectors++;
        if (obs() !== 8'b1000_0000 || ctrl_word !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_after: got %b/%08h expected 10000000/00000000", obs(), ctrl_word);
        end
        run_instr(32'h082252A0, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        int fns[5] = '{32, 34, 36, 37, 50};
        for (int k = 0; k < 40; k++) begin
            ins = $urandom;
            case ($urandom_range(0, 5))
                0, 5: begin ins[31:26] = 6'd2; ins[5:0] = 6'(fns[$urandom_range(0, 4)]); end
                1:    ins[31:26] = 6'd2;
                2:    ins[31:26] = 6'd3;
                3:    ins[31:26] = 6'd4;
                default: ;
            endcase
            run_instr(ins, $urandom_range(0, T + 2));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_sw_timeout();
        test_illegal();
        test_mul();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
